// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the result selector.
package alu_pkg;

  localparam logic [2:0] OP_SOMA  = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MULTI = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_XOR   = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // True for opcodes whose result arrives later with a Done pulse.
  function automatic logic is_multicycle(input logic [2:0] op);
    return (op == OP_MULTI) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Opcode-driven result selection; single-width results are zero-extended
// to 2W, double-width results pass straight through, reserved gives zero.
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]     sel,
  input  logic [W-1:0]   soma,
  input  logic [W-1:0]   sub,
  input  logic [W-1:0]   andop,
  input  logic [W-1:0]   orop,
  input  logic [W-1:0]   xorop,
  input  logic [2*W-1:0] multi,
  input  logic [2*W-1:0] div,
  output logic [2*W-1:0] res
);

  // Pick the operation result named by sel.
  always_comb begin
    res = '0;
    case (sel)
      OP_SOMA:  res = {{W{1'b0}}, soma};
      OP_SUB:   res = {{W{1'b0}}, sub};
      OP_MULTI: res = multi;
      OP_DIV:   res = div;
      OP_AND:   res = {{W{1'b0}}, andop};
      OP_OR:    res = {{W{1'b0}}, orop};
      OP_XOR:   res = {{W{1'b0}}, xorop};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/result_selector_reg.sv
// Captures one ALU result per request into a held output register with a
// valid/ready handshake. Multiply/divide results are waited for (bounded
// by TIMEOUT cycles); reserved opcodes and timeouts produce Err.
module result_selector_reg
  import alu_pkg::*;
#(
  parameter int W       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Start,
  input  logic [2:0]     Sel,
  input  logic [W-1:0]   Soma,
  input  logic [W-1:0]   Sub,
  input  logic [W-1:0]   AndOp,
  input  logic [W-1:0]   OrOp,
  input  logic [W-1:0]   XorOp,
  input  logic [2*W-1:0] Multi,
  input  logic [2*W-1:0] Div,
  input  logic           MultiDone,
  input  logic           DivDone,
  input  logic           OutReady,
  output logic [2*W-1:0] Out,
  output logic           OutValid,
  output logic           Busy,
  output logic           Zero,
  output logic           Err
);

  // The wait counter counts completed WAIT cycles; the timeout fires on the
  // edge where it would reach TIMEOUT, i.e. after exactly TIMEOUT WAIT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t         state;
  logic [2:0]     op_q;
  logic [7:0]     cnt;
  logic [2:0]     mux_sel;
  logic [2*W-1:0] mux_res;
  logic           wait_done;

  // In WAIT the latched opcode steers the mux; otherwise the live Sel does.
  assign mux_sel   = (state == ST_WAIT) ? op_q : Sel;
  assign wait_done = (op_q == OP_MULTI) ? MultiDone : DivDone;

  alu_result_mux #(.W(W)) u_mux (
    .sel   (mux_sel),
    .soma  (Soma),
    .sub   (Sub),
    .andop (AndOp),
    .orop  (OrOp),
    .xorop (XorOp),
    .multi (Multi),
    .div   (Div),
    .res   (mux_res)
  );

  assign Busy = (state != ST_IDLE);
  assign Zero = OutValid && (Out == '0);

  // Request FSM with registered result, flags, wait counter and opcode latch.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      Out      <= '0;
      OutValid <= 1'b0;
      Err      <= 1'b0;
      cnt      <= '0;
      op_q     <= OP_SOMA;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (Start) begin
            if (is_multicycle(Sel)) begin
              op_q  <= Sel;
              state <= ST_WAIT;
            end else begin
              // Reserved opcode yields zero from the mux.
              Out      <= mux_res;
              Err      <= (Sel == OP_RSVD);
              OutValid <= 1'b1;
              state    <= ST_HOLD;
            end
          end
        end
        ST_WAIT: begin
          // A matching Done wins over a simultaneous timeout.
          if (wait_done) begin
            Out      <= mux_res;
            Err      <= 1'b0;
            OutValid <= 1'b1;
            cnt      <= '0;
            state    <= ST_HOLD;
          end else if (cnt == CNT_LAST) begin
            Out      <= '0;
            Err      <= 1'b1;
            OutValid <= 1'b1;
            cnt      <= '0;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          cnt <= '0;
          if (OutValid && OutReady) begin
            OutValid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          OutValid <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_selector_reg.sv
// Directed bench for result_selector_reg with a handshake scoreboard.
module tb_result_selector_reg;

  localparam int W = 4;

  logic           Clk = 1'b0;
  logic           Rst_n, Start, MultiDone, DivDone, OutReady;
  logic [2:0]     Sel;
  logic [W-1:0]   Soma, Sub, AndOp, OrOp, XorOp;
  logic [2*W-1:0] Multi, Div, Out;
  logic           OutValid, Busy, Zero, Err;

  typedef struct packed {
    logic [2*W-1:0] out;
    logic           err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  result_selector_reg #(.W(W), .TIMEOUT(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Sel(Sel),
    .Soma(Soma), .Sub(Sub), .AndOp(AndOp), .OrOp(OrOp), .XorOp(XorOp),
    .Multi(Multi), .Div(Div), .MultiDone(MultiDone), .DivDone(DivDone),
    .OutReady(OutReady), .Out(Out), .OutValid(OutValid), .Busy(Busy),
    .Zero(Zero), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [2*W-1:0] o, input logic e);
    exp_t x;
    x.out = o;
    x.err = e;
    q.push_back(x);
  endtask

  // Accept one handshake: drop ready again after the accepting edge.
  task automatic handshake();
    OutReady = 1'b1;
    step();
    OutReady = 1'b0;
    chk("hs_valid_clr", 32'(OutValid), 32'd0);
    chk("hs_idle", 32'(Busy), 32'd0);
  endtask

  // Monitor: every accepted output is compared with the oldest expectation.
  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && OutValid && OutReady) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_output", 32'(Out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_out", 32'(Out), 32'(e.out));
        chk("sb_err", 32'(Err), 32'(e.err));
        chk("sb_zero", 32'(Zero), 32'(e.out == '0));
      end
    end
  end

  logic [2:0] ops [4] = '{3'd1, 3'd4, 3'd5, 3'd6};
  logic [7:0] opx [4] = '{8'h03, 8'h05, 8'h00, 8'h0F};

  initial begin
    Rst_n = 1'b0; Start = 1'b0; Sel = '0; MultiDone = 1'b0; DivDone = 1'b0;
    OutReady = 1'b0; Soma = '0; Sub = 4'h3; AndOp = 4'h5; OrOp = 4'h0;
    XorOp = 4'hF; Multi = '0; Div = '0;
    step(); step();
    chk("rst_out", 32'(Out), 32'd0);
    chk("rst_valid", 32'(OutValid), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_zero", 32'(Zero), 32'd0);
    Rst_n = 1'b1;
    step();

    // Soma single-cycle capture
    Sel = 3'd0; Soma = 4'hA; Start = 1'b1; push(8'h0A, 1'b0);
    step();
    Start = 1'b0;
    chk("soma_out", 32'(Out), 32'h0A);
    chk("soma_valid", 32'(OutValid), 32'd1);
    chk("soma_err", 32'(Err), 32'd0);
    chk("soma_zero", 32'(Zero), 32'd0);
    chk("soma_busy", 32'(Busy), 32'd1);
    handshake();
    step();

    // Remaining single-width opcodes
    for (int i = 0; i < 4; i++) begin
      Sel = ops[i]; Start = 1'b1; push(opx[i], 1'b0);
      step();
      Start = 1'b0;
      chk("single_out", 32'(Out), 32'(opx[i]));
      handshake();
      step();
    end

    // Multiply with an ignored DivDone before the matching MultiDone
    Sel = 3'd2; Multi = 8'hC8; Div = 8'h11; Start = 1'b1; push(8'hC8, 1'b0);
    step();
    Start = 1'b0; DivDone = 1'b1;
    step();
    DivDone = 1'b0;
    chk("mul_divdone_ignored", 32'(OutValid), 32'd0);
    step();
    MultiDone = 1'b1;
    step();
    MultiDone = 1'b0;
    chk("mul_out", 32'(Out), 32'hC8);
    chk("mul_valid", 32'(OutValid), 32'd1);
    chk("mul_err", 32'(Err), 32'd0);
    handshake();
    step();

    // Divide timeout after exactly 16 WAIT cycles
    Sel = 3'd3; Div = 8'h77; Start = 1'b1; push(8'h00, 1'b1);
    step();
    Start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("to_not_yet", 32'(OutValid), 32'd0);
    step();
    chk("to_valid", 32'(OutValid), 32'd1);
    chk("to_out", 32'(Out), 32'd0);
    chk("to_err", 32'(Err), 32'd1);
    chk("to_zero", 32'(Zero), 32'd1);
    handshake();
    step();

    // Hold stability under backpressure, Start and operand changes
    Sel = 3'd0; Soma = 4'h6; Start = 1'b1; push(8'h06, 1'b0);
    step();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Soma = 4'(i + 9); Start = i[0];
      step();
      chk("hold_out", 32'(Out), 32'h06);
      chk("hold_valid", 32'(OutValid), 32'd1);
    end
    Start = 1'b1;
    handshake();
    Start = 1'b0;
    step();
    chk("hold_no_restart", 32'(OutValid), 32'd0);
    step();

    // Reserved opcode
    Sel = 3'd7; Start = 1'b1; push(8'h00, 1'b1);
    step();
    Start = 1'b0;
    chk("rsvd_out", 32'(Out), 32'd0);
    chk("rsvd_err", 32'(Err), 32'd1);
    handshake();
    step();

    // Reset during WAIT aborts; later MultiDone produces nothing
    Sel = 3'd2; Multi = 8'h3C; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    Rst_n = 1'b0; MultiDone = 1'b1;
    step();
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_valid", 32'(OutValid), 32'd0);
    Rst_n = 1'b1; MultiDone = 1'b0; OutReady = 1'b1;
    step();
    MultiDone = 1'b1;
    step();
    MultiDone = 1'b0;
    step();
    chk("abort_no_output", 32'(OutValid), 32'd0);
    OutReady = 1'b0;
    step();

    // DivDone in the timeout cycle wins
    Sel = 3'd3; Div = 8'h5B; Start = 1'b1; push(8'h5B, 1'b0);
    step();
    Start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    DivDone = 1'b1;
    step();
    DivDone = 1'b0;
    chk("race_out", 32'(Out), 32'h5B);
    chk("race_err", 32'(Err), 32'd0);
    handshake();
    step(); step();

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
